bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter between the fetch stage (instruction line fills) and the memory stage (data loads and stores) and the single Sysbus port of `top`. It serialises transactions so that only one is outstanding at a time. It forwards request beats from the granted stage and routes response beats back to the stage that owns the transaction. It replaces the direct, shared wiring of both stages onto `bus_*`.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, width of the request/response data and address beats
- BUS_TAG_WIDTH, 13, width of the Sysbus tag; bit [BUS_TAG_WIDTH-1] = 1 marks a write
- BEATS, 8, data beats per transaction (64-byte line)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- if_reqcyc / if_req / if_reqtag  in  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  fetch-stage request
- if_reqack  out  1  fetch request beat accepted
- if_respcyc / if_resp / if_resptag  out  1 / BUS_DATA_WIDTH / BUS_TAG_WIDTH  fetch response beat
- if_respack  in  1  fetch consumed the response beat
- mem_reqcyc / mem_req / mem_reqtag / mem_reqack / mem_respcyc / mem_resp / mem_resptag / mem_respack  same as `if_*`, for the memory stage
- bus_reqcyc / bus_req / bus_reqtag  out  Sysbus request
- bus_reqack  in  1
- bus_respcyc / bus_resp / bus_resptag  in  Sysbus response
- bus_respack  out  1

## Operation
- States: IDLE, REQ (address beat), WDATA (write data beats), RESP (read response beats).
- IDLE: sample `if_reqcyc` and `mem_reqcyc`.
  - If only one is asserted, grant it.
  - If both are asserted, grant the master that was not granted last. `last_grant` resets to fetch, so mem wins the first tie.
  - Register the owner and the write bit from the owner's `reqtag`, then go to REQ.
- REQ:
  - `bus_reqcyc/req/reqtag` mirror the owner's live inputs.
  - The owner's `reqack` = `bus_reqack`.
  - On `bus_reqack`: a write goes to WDATA with `beat_cnt` = 0; a read goes to RESP with `beat_cnt` = 0.
- WDATA:
  - Pass-through as in REQ.
  - Each `bus_reqack` increments `beat_cnt`.
  - The ack with `beat_cnt` = BEATS-1 returns to IDLE. Writes have no response phase.
- RESP:
  - Owner's `respcyc/resp/resptag` = bus values; `bus_respack` = owner's `respack`.
  - A beat completes when `bus_respcyc && bus_respack`; it increments `beat_cnt`.
  - The final beat (BEATS-1) returns to IDLE.
- Non-owner stage outputs are always 0.
- The owner must hold `reqcyc` from grant until its final request beat is acked. Dropping it early is a protocol error; the arbiter still follows `bus_reqack`.
- A stray `bus_respcyc` in IDLE, REQ or WDATA is acked (`bus_respack` = 1) and dropped.
- `beat_cnt` is $clog2(BEATS) bits wide and never wraps within a transaction.

## Timing
- Reset: state IDLE, `last_grant` = fetch, `beat_cnt` = 0; every output is 0.
- Request seen in IDLE at cycle N → `bus_reqcyc` = 1 from cycle N+1. Arbitration costs 1 cycle.
- `reqack` and `respcyc` paths are combinational through the owner mux; there is no added latency.
- The final beat completes at cycle M → IDLE at M+1. The next grant can appear at M+1, with `bus_reqcyc` at M+2.
- A request arriving in the same cycle as the final beat waits for IDLE. It is not granted in that cycle.
- Reset mid-transaction aborts it immediately. The stage is responsible for re-issuing.

## Configuration
- BUS_ARBITER_TAGCHECK_EN defined:
  - The issued `reqtag` is latched at grant.
  - In RESP, a beat whose `bus_resptag` differs from the latched tag is acked and dropped. It is not forwarded and not counted.
  - The sticky status bit `tag_err` (output, 1 bit, reset 0) is set.
- Undefined:
  - No tag compare; every RESP beat goes to the owner.
  - `tag_err` is tied to 0.

## Structure
- `bus_arbiter_pkg` holds:
  - `arb_state_t` enum (IDLE, REQ, WDATA, RESP)
  - `arb_owner_t` enum (OWN_IF, OWN_MEM)
  - the write-bit index constant
- One sub-module: `bus_arbiter_rr`. It is the two-way round-robin picker. It takes both requests and `last_grant` and returns the grant plus a valid flag.

## Test plan
- Fetch read alone: `if_reqcyc` at cycle 2 with addr 0x1000 → `bus_reqcyc` at cycle 3. After ack, 8 response beats 0xA0..0xA7 appear on `if_resp`, and `mem_respcyc` stays 0 throughout.
- Simultaneous requests after reset → mem granted first. Fetch is granted on the next IDLE and its `bus_reqcyc` rises 2 cycles after mem's final beat.
- Mem write with tag bit 12 = 1 → address beat plus 8 data beats are passed through with `bus_reqack` stalls of 0–3 cycles. There is no RESP phase and the block returns to IDLE after the 8th ack.
- Response backpressure: hold `if_respack` = 0 for 4 cycles mid-burst → `bus_respack` = 0 for those cycles and `beat_cnt` freezes. Exactly 8 beats are delivered.
- Reset asserted at beat 3 of a read → all outputs are 0 the next cycle and the state is IDLE. A fresh mem request is granted normally.
- With BUS_ARBITER_TAGCHECK_EN: one injected beat with a wrong tag → it is dropped, `tag_err` = 1, and the 8 correct beats still complete the transaction.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the two-master Sysbus arbiter
`timescale 1ns/1ps
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WDATA,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } arb_owner_t;

  // The write flag is the most significant bit of the Sysbus tag.
  function automatic int write_bit_idx(input int tag_width);
    return tag_width - 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - two-way round-robin picker between fetch and memory stage
`timescale 1ns/1ps
module bus_arbiter_rr (
  input  logic req_if,
  input  logic req_mem,
  input  logic last_mem,
  output logic grant_mem,
  output logic valid
);

  // On a tie the stage that did not win last time gets the bus.
  always_comb begin
    valid     = req_if | req_mem;
    grant_mem = 1'b0;
    if (req_if && req_mem) begin
      grant_mem = ~last_mem;
    end else begin
      grant_mem = req_mem;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - serialising Sysbus arbiter for fetch and memory stages (optional BUS_ARBITER_TAGCHECK_EN)
`timescale 1ns/1ps
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      if_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] if_req,
  input  logic [BUS_TAG_WIDTH-1:0]  if_reqtag,
  output logic                      if_reqack,
  output logic                      if_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] if_resp,
  output logic [BUS_TAG_WIDTH-1:0]  if_resptag,
  input  logic                      if_respack,
  input  logic                      mem_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] mem_req,
  input  logic [BUS_TAG_WIDTH-1:0]  mem_reqtag,
  output logic                      mem_reqack,
  output logic                      mem_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] mem_resp,
  output logic [BUS_TAG_WIDTH-1:0]  mem_resptag,
  input  logic                      mem_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      tag_err
);

  localparam int WB = write_bit_idx(BUS_TAG_WIDTH);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  arb_state_t state, state_nxt;
  arb_owner_t owner, owner_nxt;
  arb_owner_t last_grant, last_grant_nxt;
  logic          is_write, is_write_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;

  logic rr_valid, rr_grant_mem;
  logic tag_ok;
  logic beat_done;

  logic                      own_mem;
  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;

  bus_arbiter_rr u_rr (
    .req_if    (if_reqcyc),
    .req_mem   (mem_reqcyc),
    .last_mem  (last_grant == OWN_MEM),
    .grant_mem (rr_grant_mem),
    .valid     (rr_valid)
  );

  assign own_mem     = (owner == OWN_MEM);
  assign own_reqcyc  = own_mem ? mem_reqcyc  : if_reqcyc;
  assign own_req     = own_mem ? mem_req     : if_req;
  assign own_reqtag  = own_mem ? mem_reqtag  : if_reqtag;
  assign own_respack = own_mem ? mem_respack : if_respack;
  assign beat_done   = bus_respcyc && own_respack && tag_ok;

`ifdef BUS_ARBITER_TAGCHECK_EN
  logic [BUS_TAG_WIDTH-1:0] tag_q;
  logic                     tag_err_q;

  // Remember the issued tag at grant; flag any response beat carrying another tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      if (state == IDLE && rr_valid) begin
        tag_q <= rr_grant_mem ? mem_reqtag : if_reqtag;
      end
      if (state == RESP && bus_respcyc && !tag_ok) begin
        tag_err_q <= 1'b1;
      end
    end
  end

  assign tag_ok  = (bus_resptag == tag_q);
  assign tag_err = tag_err_q;
`else
  assign tag_ok  = 1'b1;
  assign tag_err = 1'b0;
`endif

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      is_write   <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      is_write   <= is_write_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Next-state sequencing plus the owner mux onto the bus and back.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    is_write_nxt   = is_write;
    beat_cnt_nxt   = beat_cnt;

    if_reqack   = 1'b0;
    if_respcyc  = 1'b0;
    if_resp     = '0;
    if_resptag  = '0;
    mem_reqack  = 1'b0;
    mem_respcyc = 1'b0;
    mem_resp    = '0;
    mem_resptag = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;

    case (state)
      IDLE: begin
        if (rr_valid) begin
          owner_nxt      = arb_owner_t'(rr_grant_mem);
          last_grant_nxt = arb_owner_t'(rr_grant_mem);
          is_write_nxt   = rr_grant_mem ? mem_reqtag[WB] : if_reqtag[WB];
          beat_cnt_nxt   = '0;
          state_nxt      = REQ;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          beat_cnt_nxt = '0;
          state_nxt    = is_write ? WDATA : RESP;
        end
      end
      WDATA: begin
        if (bus_reqack) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end
      end
      RESP: begin
        if (beat_done) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs stay quiet while reset is held so nothing leaks from an aborted transfer.
    if (!reset) begin
      case (state)
        REQ, WDATA: begin
          bus_reqcyc  = own_reqcyc;
          bus_req     = own_req;
          bus_reqtag  = own_reqtag;
          bus_respack = bus_respcyc;
          if (own_mem) begin
            mem_reqack = bus_reqack;
          end else begin
            if_reqack = bus_reqack;
          end
        end
        RESP: begin
          if (tag_ok) begin
            bus_respack = own_respack;
            if (own_mem) begin
              mem_respcyc = bus_respcyc;
              mem_resp    = bus_resp;
              mem_resptag = bus_resptag;
            end else begin
              if_respcyc = bus_respcyc;
              if_resp    = bus_resp;
              if_resptag = bus_resptag;
            end
          end else begin
            bus_respack = bus_respcyc;
          end
        end
        default: bus_respack = bus_respcyc;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (tag checks under BUS_ARBITER_TAGCHECK_EN)
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_reqcyc, if_reqack, if_respcyc, if_respack;
  logic [DW-1:0] if_req, if_resp;
  logic [TW-1:0] if_reqtag, if_resptag;
  logic          mem_reqcyc, mem_reqack, mem_respcyc, mem_respack;
  logic [DW-1:0] mem_req, mem_resp;
  logic [TW-1:0] mem_reqtag, mem_resptag;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [DW-1:0] bus_req, bus_resp;
  logic [TW-1:0] bus_reqtag, bus_resptag;
  logic          tag_err;

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .if_reqcyc(if_reqcyc), .if_req(if_req), .if_reqtag(if_reqtag), .if_reqack(if_reqack),
    .if_respcyc(if_respcyc), .if_resp(if_resp), .if_resptag(if_resptag), .if_respack(if_respack),
    .mem_reqcyc(mem_reqcyc), .mem_req(mem_req), .mem_reqtag(mem_reqtag), .mem_reqack(mem_reqack),
    .mem_respcyc(mem_respcyc), .mem_resp(mem_resp), .mem_resptag(mem_resptag), .mem_respack(mem_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          if_reqack;
    logic          mem_reqack;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          if_respcyc;
    logic [DW-1:0] if_resp;
    logic [TW-1:0] if_resptag;
    logic          mem_respcyc;
    logic [DW-1:0] mem_resp;
    logic [TW-1:0] mem_resptag;
    logic          bus_respack;
    logic          tag_err;
  } outs_t;

  typedef struct {
    bit if_rq;
    bit mem_rq;
    bit if_wr;
    bit mem_wr;
    int exp_own;
  } vec_t;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [TW-1:0] cur_tag;
  logic          tag_err_exp;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outs_t actual();
    outs_t o;
    o.if_reqack   = if_reqack;   o.mem_reqack  = mem_reqack;
    o.bus_reqcyc  = bus_reqcyc;  o.bus_req     = bus_req;     o.bus_reqtag  = bus_reqtag;
    o.if_respcyc  = if_respcyc;  o.if_resp     = if_resp;     o.if_resptag  = if_resptag;
    o.mem_respcyc = mem_respcyc; o.mem_resp    = mem_resp;    o.mem_resptag = mem_resptag;
    o.bus_respack = bus_respack; o.tag_err     = tag_err;
    return o;
  endfunction

  // Expected outputs by phase: 0 idle, 1 request forwarding, 2 response routing, 3 all quiet.
  function automatic outs_t model(input int ph, input int own);
    outs_t o = '0;
    bit    tag_good = 1'b1;
    o.tag_err = tag_err_exp;
`ifdef BUS_ARBITER_TAGCHECK_EN
    tag_good = (bus_resptag == cur_tag);
`endif
    case (ph)
      1: begin
        o.bus_reqcyc  = own ? mem_reqcyc : if_reqcyc;
        o.bus_req     = own ? mem_req    : if_req;
        o.bus_reqtag  = own ? mem_reqtag : if_reqtag;
        o.mem_reqack  = own ? bus_reqack : 1'b0;
        o.if_reqack   = own ? 1'b0 : bus_reqack;
        o.bus_respack = bus_respcyc;
      end
      2: begin
        if (tag_good) begin
          o.bus_respack = own ? mem_respack : if_respack;
          if (own) begin
            o.mem_respcyc = bus_respcyc; o.mem_resp = bus_resp; o.mem_resptag = bus_resptag;
          end else begin
            o.if_respcyc = bus_respcyc; o.if_resp = bus_resp; o.if_resptag = bus_resptag;
          end
        end else begin
          o.bus_respack = bus_respcyc;
        end
      end
      3: o = '0;
      default: o.bus_respack = bus_respcyc;
    endcase
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string name, input int ph, input int own);
    #1;
    chk(name, actual(), model(ph, own));
  endtask

  task automatic drive_req(input int m, input logic cyc, input logic [DW-1:0] d, input logic [TW-1:0] t);
    if (m != 0) begin
      mem_reqcyc = cyc; mem_req = d; mem_reqtag = t;
    end else begin
      if_reqcyc = cyc; if_req = d; if_reqtag = t;
    end
  endtask

  task automatic set_respack(input int m, input logic v);
    if (m != 0) mem_respack = v;
    else if_respack = v;
  endtask

  task automatic arb_cycle();
    look("idle arbitration", 0, 0);
    tick();
  endtask

  // Runs one granted transaction from its REQ cycle to the IDLE cycle that follows it.
  task automatic run_txn(input int own, input bit wr, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                         input logic [DW-1:0] dbase, input int stall_max, input int gap_max,
                         input int bp_max, input int hold_beat, input bit inject_bad);
    int nreq, stall, gap, bp, got;
    cur_tag = tag;
    nreq = wr ? BEATS + 1 : 1;
    for (int b = 0; b < nreq; b++) begin
      drive_req(own, 1'b1, (b == 0) ? addr : dbase + DW'(b - 1), tag);
      stall = $urandom_range(stall_max, 0);
      for (int s = 0; s <= stall; s++) begin
        bus_reqack  = (s == stall);
        bus_respcyc = ($urandom_range(3, 0) == 0);
        bus_resp    = {$urandom, $urandom};
        bus_resptag = TW'($urandom);
        look(wr ? "write request beat" : "read address beat", 1, own);
        tick();
      end
    end
    drive_req(own, 1'b0, '0, '0);
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    if (!wr) begin
      got = 0;
      for (int k = 0; k < BEATS; k++) begin
        if (inject_bad && k == 4) begin
          bus_respcyc = 1'b1; bus_resp = '1; bus_resptag = tag ^ TW'(1);
          set_respack(own, 1'b1);
          look("wrong tag beat", 2, own);
          tick();
          tag_err_exp = 1'b1;
        end
        gap = $urandom_range(gap_max, 0);
        for (int g = 0; g < gap; g++) begin
          bus_respcyc = 1'b0; bus_resp = {$urandom, $urandom}; bus_resptag = tag;
          set_respack(own, 1'($urandom_range(1, 0)));
          look("response gap", 2, own);
          tick();
        end
        bp = (k == hold_beat) ? 4 : $urandom_range(bp_max, 0);
        bus_respcyc = 1'b1; bus_resp = dbase + DW'(k); bus_resptag = tag;
        for (int j = 0; j <= bp; j++) begin
          set_respack(own, j == bp);
          look("response beat", 2, own);
          if (own != 0 ? (mem_respcyc && mem_respack) : (if_respcyc && if_respack)) begin
            got++;
            chk("response data order", own != 0 ? mem_resp : if_resp, dbase + DW'(k));
          end
          tick();
        end
      end
      bus_respcyc = 1'b0;
      set_respack(own, 1'b0);
      chk("beats delivered", got, BEATS);
    end
  endtask

  vec_t          vecs[8];
  bit            pending[2];
  bit            p_wr[2];
  logic [DW-1:0] p_addr[2];
  logic [TW-1:0] p_tag[2];
  int            last_own, win, m;

  initial begin
    // Expected winners follow from round-robin starting with fetch as last grant.
    vecs[0] = '{1, 1, 0, 0, 1};
    vecs[1] = '{1, 1, 0, 0, 0};
    vecs[2] = '{1, 0, 1, 0, 0};
    vecs[3] = '{1, 1, 0, 0, 1};
    vecs[4] = '{0, 1, 0, 1, 1};
    vecs[5] = '{1, 1, 0, 0, 0};
    vecs[6] = '{1, 1, 1, 1, 1};
    vecs[7] = '{1, 1, 1, 0, 0};

    reset = 1'b1;
    if_reqcyc = 0; if_req = '0; if_reqtag = '0; if_respack = 0;
    mem_reqcyc = 0; mem_req = '0; mem_reqtag = '0; mem_respack = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    tag_err_exp = 1'b0; cur_tag = '0;
    repeat (3) tick();
    bus_respcyc = 1'b1;
    look("outputs during reset", 3, 0);
    bus_respcyc = 1'b0;
    reset = 1'b0;
    look("outputs after reset", 0, 0);
    tick();

    // Fetch read alone, data 0xA0..0xA7.
    tick();
    drive_req(0, 1'b1, 64'h1000, 13'h0042);
    arb_cycle();
    run_txn(0, 1'b0, 64'h1000, 13'h0042, 64'hA0, 2, 1, 2, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].if_rq)  drive_req(0, 1'b1, 64'h2000 + DW'(i * 64), {vecs[i].if_wr, 12'(12'h100 + i)});
      if (vecs[i].mem_rq) drive_req(1, 1'b1, 64'h8000 + DW'(i * 64), {vecs[i].mem_wr, 12'(12'h200 + i)});
      arb_cycle();
      drive_req(1 - vecs[i].exp_own, 1'b0, '0, '0);
      if (vecs[i].exp_own != 0)
        run_txn(1, vecs[i].mem_wr, 64'h8000 + DW'(i * 64), {vecs[i].mem_wr, 12'(12'h200 + i)},
                DW'(i) << 8, 3, 1, 1, -1, 1'b0);
      else
        run_txn(0, vecs[i].if_wr, 64'h2000 + DW'(i * 64), {vecs[i].if_wr, 12'(12'h100 + i)},
                DW'(i) << 8, 3, 1, 1, -1, 1'b0);
    end

    // Response backpressure: four cycles without respack on beat 3.
    drive_req(0, 1'b1, 64'h3000, 13'h0077);
    arb_cycle();
    run_txn(0, 1'b0, 64'h3000, 13'h0077, 64'hB0, 0, 0, 0, 3, 1'b0);

    // Mem read aborted by reset at beat 3.
    drive_req(1, 1'b1, 64'h4000, 13'h0099);
    cur_tag = 13'h0099;
    arb_cycle();
    bus_reqack = 1'b1;
    look("aborted read address", 1, 1);
    tick();
    drive_req(1, 1'b0, '0, '0);
    bus_reqack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hC0 + DW'(k); bus_resptag = 13'h0099; mem_respack = 1'b1;
      look("aborted read beat", 2, 1);
      tick();
    end
    reset = 1'b1;
    bus_resp = 64'hC3;
    tick();
    reset = 1'b0; bus_respcyc = 1'b0; mem_respack = 1'b0;
    look("outputs cycle after mid-burst reset", 3, 0);
    tick();

    // Tie after reset goes to mem; waiting fetch follows two cycles after mem's last beat.
    drive_req(0, 1'b1, 64'h5000, 13'h0011);
    drive_req(1, 1'b1, 64'h6000, 13'h1022);
    arb_cycle();
    run_txn(1, 1'b1, 64'h6000, 13'h1022, 64'hD0, 3, 0, 0, -1, 1'b0);
    arb_cycle();
    run_txn(0, 1'b0, 64'h5000, 13'h0011, 64'hE0, 1, 1, 1, -1, 1'b0);

    // Randomised traffic against a round-robin reference.
    last_own = 0;
    pending[0] = 1'b0; pending[1] = 1'b0;
    for (int ep = 0; ep < 40; ep++) begin
      for (int q = 0; q < 3; q++) begin
        m = (q < 2) ? q : int'($urandom_range(1, 0));
        if (!pending[m] && (q == 2 ? !(pending[0] || pending[1]) : ($urandom_range(1, 0) == 1))) begin
          pending[m] = 1'b1;
          p_wr[m]    = 1'($urandom_range(1, 0));
          p_tag[m]   = {p_wr[m], 12'($urandom)};
          p_addr[m]  = {$urandom, $urandom};
          drive_req(m, 1'b1, p_addr[m], p_tag[m]);
        end
      end
      win = (pending[0] && pending[1]) ? 1 - last_own : (pending[1] ? 1 : 0);
      last_own = win;
      arb_cycle();
      run_txn(win, p_wr[win], p_addr[win], p_tag[win], {$urandom, $urandom}, 3, 2, 3, -1, 1'b0);
      pending[win] = 1'b0;
    end

`ifdef BUS_ARBITER_TAGCHECK_EN
    drive_req(0, 1'b1, 64'h7000, 13'h0123);
    arb_cycle();
    run_txn(0, 1'b0, 64'h7000, 13'h0123, 64'hF0, 0, 0, 0, -1, 1'b1);
    look("tag_err sticky in idle", 0, 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
